// File: rtl/z16_pkg.sv
// rtl/z16_pkg.sv - Z16 core shared widths and types (decoder, ALU, register file)
package z16_pkg;

  localparam int Z16_DATA_W     = 16;
  localparam int Z16_REG_ADDR_W = 4;
  localparam int Z16_NUM_REGS   = 1 << Z16_REG_ADDR_W;

  typedef logic [Z16_DATA_W-1:0]     z16_word_t;
  typedef logic [Z16_REG_ADDR_W-1:0] z16_reg_addr_t;

endpackage : z16_pkg

// File: rtl/z16_rf_read_port.sv
// rtl/z16_rf_read_port.sv - 16:1 register read mux with optional write forwarding (Z16_RF_BYPASS_EN)
module z16_rf_read_port
  import z16_pkg::*;
#(
  parameter int DATA_W = Z16_DATA_W,
  parameter int ADDR_W = Z16_REG_ADDR_W
) (
  input  logic                              i_rst_n,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] i_regs,
  input  logic [ADDR_W-1:0]                 i_addr,
  input  logic                              i_rd_wen,
  input  logic [ADDR_W-1:0]                 i_rd_addr,
  input  logic [DATA_W-1:0]                 i_rd_data,
  output logic [DATA_W-1:0]                 o_data
);

  logic [DATA_W-1:0] w_data;

`ifdef Z16_RF_BYPASS_EN
  // Select the stored word, overridden by the in-flight write when it targets the same register
  always_comb begin
    w_data = i_regs[i_addr];
    // Gated by reset so the port keeps reading zero while the array is held clear
    if (i_rst_n && i_rd_wen && (i_rd_addr == i_addr)) begin
      w_data = i_rd_data;
    end
  end
`else
  // Write-port signals are only consumed by the forwarding path
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_rst_n, i_rd_wen, i_rd_addr, i_rd_data};

  // Select the stored word; a same-cycle write is seen only after the clock edge
  always_comb begin
    w_data = i_regs[i_addr];
  end
`endif

  assign o_data = w_data;

endmodule : z16_rf_read_port

// File: rtl/z16_register_file.sv
// rtl/z16_register_file.sv - Z16 16x16 register file, 2 async read ports, 1 sync write port (Z16_RF_BYPASS_EN)
module z16_register_file
  import z16_pkg::*;
#(
  parameter int DATA_W = Z16_DATA_W,
  parameter int ADDR_W = Z16_REG_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_wen,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  // Storage array: cleared immediately by reset, otherwise one decoded write per clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regs <= '0;
    end else if (i_rd_wen) begin
      r_regs[i_rd_addr] <= i_rd_data;
    end
  end

  z16_rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs1_port (
    .i_rst_n   (i_rst_n),
    .i_regs    (r_regs),
    .i_addr    (i_rs1_addr),
    .i_rd_wen  (i_rd_wen),
    .i_rd_addr (i_rd_addr),
    .i_rd_data (i_rd_data),
    .o_data    (o_rs1_data)
  );

  z16_rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs2_port (
    .i_rst_n   (i_rst_n),
    .i_regs    (r_regs),
    .i_addr    (i_rs2_addr),
    .i_rd_wen  (i_rd_wen),
    .i_rd_addr (i_rd_addr),
    .i_rd_data (i_rd_data),
    .o_data    (o_rs2_data)
  );

endmodule : z16_register_file

// File: tb/tb_z16_register_file.sv
// tb/tb_z16_register_file.sv - directed self-checking bench for z16_register_file (Z16_RF_BYPASS_EN aware)
module tb_z16_register_file;

  logic        i_clk;
  logic        i_rst_n;
  logic [3:0]  i_rs1_addr;
  logic [3:0]  i_rs2_addr;
  logic [3:0]  i_rd_addr;
  logic        i_rd_wen;
  logic [15:0] i_rd_data;
  logic [15:0] o_rs1_data;
  logic [15:0] o_rs2_data;

  int n_checks;
  int n_fails;

  z16_register_file dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .i_rd_addr  (i_rd_addr),
    .i_rd_wen   (i_rd_wen),
    .i_rd_data  (i_rd_data),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one write in the low phase so it lands on the following rising edge
  task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
    @(negedge i_clk);
    i_rd_wen  = 1'b1;
    i_rd_addr = addr;
    i_rd_data = data;
    @(posedge i_clk);
    #1;
    i_rd_wen  = 1'b0;
    i_rd_addr = 'x;
    i_rd_data = 'x;
  endtask

  logic [15:0] exp_before;

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    i_rst_n    = 1'b0;
    i_rd_wen   = 1'b0;
    i_rd_addr  = 4'h0;
    i_rd_data  = 16'h0000;
    i_rs1_addr = 4'h0;
    i_rs2_addr = 4'h0;

    // Reset: every address reads zero on both ports
    #2;
    for (int i = 0; i < 16; i++) begin
      i_rs1_addr = 4'(i);
      i_rs2_addr = 4'(15 - i);
      #1;
      check_eq($sformatf("reset_rs1_r%0d", i), o_rs1_data, 16'h0000);
      check_eq($sformatf("reset_rs2_r%0d", 15 - i), o_rs2_data, 16'h0000);
    end

    // Writes attempted while in reset must be discarded
    i_rd_wen  = 1'b1;
    i_rd_addr = 4'h0;
    i_rd_data = 16'h1234;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rd_wen = 1'b0;
    i_rst_n  = 1'b1;
    i_rs1_addr = 4'h0;
    #1;
    check_eq("write_in_reset_lost", o_rs1_data, 16'h0000);

    // Basic write/read
    write_reg(4'hA, 16'h5555);
    i_rs1_addr = 4'hA;
    #1;
    check_eq("basic_rs1_r10", o_rs1_data, 16'h5555);
    i_rs2_addr = 4'hA;
    #1;
    check_eq("basic_rs2_r10", o_rs2_data, 16'h5555);
    i_rs2_addr = 4'hB;
    #1;
    check_eq("basic_rs2_r11", o_rs2_data, 16'h0000);

    // Write-enable gating
    @(negedge i_clk);
    i_rd_wen  = 1'b0;
    i_rd_addr = 4'h3;
    i_rd_data = 16'hFFFF;
    repeat (3) @(posedge i_clk);
    #1;
    i_rs1_addr = 4'h3;
    #1;
    check_eq("wen_gating_r3", o_rs1_data, 16'h0000);

    // All registers through both ports
    for (int n = 0; n < 16; n++) write_reg(4'(n), 16'h1000 + 16'(n));
    for (int n = 0; n < 16; n++) begin
      i_rs1_addr = 4'(n);
      i_rs2_addr = 4'(n);
      #1;
      check_eq($sformatf("all_rs1_r%0d", n), o_rs1_data, 16'h1000 + 16'(n));
      check_eq($sformatf("all_rs2_r%0d", n), o_rs2_data, 16'h1000 + 16'(n));
    end
    i_rs1_addr = 4'h2;
    i_rs2_addr = 4'hF;
    #1;
    check_eq("dual_rs1_r2", o_rs1_data, 16'h1002);
    check_eq("dual_rs2_r15", o_rs2_data, 16'h100F);

    // Same-cycle read of the register being written
    write_reg(4'h5, 16'hAAAA);
`ifdef Z16_RF_BYPASS_EN
    exp_before = 16'h1234;
`else
    exp_before = 16'hAAAA;
`endif
    @(negedge i_clk);
    i_rs1_addr = 4'h5;
    i_rs2_addr = 4'h5;
    i_rd_wen   = 1'b1;
    i_rd_addr  = 4'h5;
    i_rd_data  = 16'h1234;
    #1;
    check_eq("same_cycle_rs1_before", o_rs1_data, exp_before);
    check_eq("same_cycle_rs2_before", o_rs2_data, exp_before);
    @(posedge i_clk);
    #1;
    i_rd_wen = 1'b0;
    #1;
    check_eq("same_cycle_rs1_after", o_rs1_data, 16'h1234);
    check_eq("same_cycle_rs2_after", o_rs2_data, 16'h1234);

    // Asynchronous reset between edges
    write_reg(4'h7, 16'hBEEF);
    i_rs1_addr = 4'h7;
    i_rs2_addr = 4'hA;
    #1;
    check_eq("pre_reset_r7", o_rs1_data, 16'hBEEF);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_eq("async_reset_r7", o_rs1_data, 16'h0000);
    check_eq("async_reset_r10", o_rs2_data, 16'h0000);

    // Write during reset, including a would-be forward, stays invisible
    i_rd_wen  = 1'b1;
    i_rd_addr = 4'h7;
    i_rd_data = 16'h4321;
    #1;
    check_eq("reset_no_forward_r7", o_rs1_data, 16'h0000);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rd_wen = 1'b0;
    i_rst_n  = 1'b1;
    #1;
    check_eq("reset_write_lost_r7", o_rs1_data, 16'h0000);

    // First write after release succeeds
    write_reg(4'h7, 16'h5678);
    #1;
    check_eq("post_release_write_r7", o_rs1_data, 16'h5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_z16_register_file

// File: doc/z16_register_file.md
# z16_register_file

General-purpose register file of the Z16 16-bit CPU core: sixteen 16-bit registers with two asynchronous read ports (rs1, rs2) and one synchronous write port (rd). It sits between the decode stage, which supplies the register addresses, and the execute/ALU stage. Writeback drives the rd port.

## Interface
Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, register address width; register count is 2**ADDR_W = 16.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- i_rs1_addr  input  ADDR_W  read port 1 register index.
- i_rs2_addr  input  ADDR_W  read port 2 register index.
- i_rd_addr  input  ADDR_W  write port register index.
- i_rd_wen  input  1  write enable for the rd port, active-high.
- i_rd_data  input  DATA_W  write data.
- o_rs1_data  output  DATA_W  contents of the register at i_rs1_addr.
- o_rs2_data  output  DATA_W  contents of the register at i_rs2_addr.

## Operation
- Storage is 16 registers, r0..r15, each DATA_W bits wide. All are general purpose, with no hardwired-zero register.
- Write: on the rising edge of i_clk, with i_rst_n high and i_rd_wen = 1, the register at index i_rd_addr takes i_rd_data. With i_rd_wen = 0, no register changes. i_rd_addr and i_rd_data are don't-care (X tolerated) while i_rd_wen = 0.
- Read: o_rs1_data and o_rs2_data are purely combinational muxes of the register array. Each output follows its address input in the same cycle, with no clock latency.
- Both read ports are independent. They may address the same register, or the register being written, with no restriction.
- Reset: while i_rst_n = 0, all 16 registers are forced to 16'h0000 immediately, without waiting for a clock edge. Both outputs therefore read 16'h0000 during reset.
- Writes asserted while i_rst_n = 0 are discarded.
- Reset deasserted mid-operation: the first write takes effect on the first rising edge with i_rst_n = 1.

## Timing
- Write latency: 1 clock. Data written at edge N is visible on the read ports immediately after edge N.
- Read latency: 0 clocks (combinational from address to data).
- Same-cycle read of the register being written (address match while i_rd_wen = 1):
  - Without the bypass macro, the output shows the old value until the edge.
  - With the bypass macro, see Configuration.
- Simultaneous write and both reads to the same address are legal, and both ports behave identically.
- No handshake and no stalls: every cycle accepts a write.

## Configuration
- Macro Z16_RF_BYPASS_EN.
- Defined: write-to-read forwarding is active. If i_rd_wen = 1 and i_rsN_addr == i_rd_addr, then o_rsN_data = i_rd_data combinationally in that cycle. This applies to each port independently. Forwarding is suppressed while i_rst_n = 0, so the outputs stay at 0 during reset.
- Undefined: no forwarding, and reads always return the stored array value.

## Structure
- Shared package z16_pkg: Z16_DATA_W = 16, Z16_REG_ADDR_W = 4, Z16_NUM_REGS = 16, and typedefs z16_word_t and z16_reg_addr_t. These are shared with the decoder and ALU.
- One natural sub-module: z16_rf_read_port. It contains the 16:1 read mux plus the optional bypass compare, and is instantiated twice (rs1, rs2).
- The storage array and write decode live in the top module.

## Test plan
- Reset: hold i_rst_n = 0, sweep i_rs1_addr and i_rs2_addr over 0..15 -> both outputs are 16'h0000 for every address.
- Basic write/read:
  - Write 16'h5555 to r10 (i_rd_wen pulse for 1 cycle), then set i_rs1_addr = 4'hA -> o_rs1_data = 16'h5555.
  - Then set i_rs2_addr = 4'hA -> o_rs2_data = 16'h5555.
  - Then set i_rs2_addr = 4'hB -> o_rs2_data = 16'h0000.
- Write-enable gating: i_rd_wen = 0, i_rd_addr = 4'h3, i_rd_data = 16'hFFFF over several edges -> r3 still reads 16'h0000.
- All registers: write 16'h1000 + n to rn for n = 0..15, then read back through both ports -> each port returns 16'h1000 + n. Also read rs1 = r2 and rs2 = r15 in the same cycle -> 16'h1002 and 16'h100F.
- Same-cycle read of a write: r5 holds 16'hAAAA, then write 16'h1234 to r5 while i_rs1_addr = 5:
  - Before the edge -> o_rs1_data = 16'hAAAA without Z16_RF_BYPASS_EN, or 16'h1234 with it.
  - After the edge -> 16'h1234 in both builds.
- Asynchronous reset mid-run: r7 holds 16'hBEEF, drop i_rst_n between clock edges -> o_rs1_data (addr 7) goes to 16'h0000 before the next edge. A write asserted during reset is lost, and the first write after release succeeds.
